// File: rtl/control_unit_if.sv
// Instruction-memory and ALU bus between control_unit (master) and its
// memory/ALU neighbours (slave).
interface control_unit_if;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [3:0]  alu_opcode;
    logic        alu_type;
    logic [7:0]  alu_reg1;
    logic [7:0]  alu_reg2;
    logic [7:0]  alu_pc;
    logic [7:0]  alu_jmpAdd;
    logic [7:0]  exc_out;
    logic [7:0]  exc_jmpAdd;
    logic        load;

    modport master (
        output imem_addr, imem_rd, alu_opcode, alu_type, alu_reg1, alu_reg2, alu_pc, alu_jmpAdd,
        input  imem_data, imem_valid, exc_out, exc_jmpAdd, load
    );

    modport slave (
        input  imem_addr, imem_rd, alu_opcode, alu_type, alu_reg1, alu_reg2, alu_pc, alu_jmpAdd,
        output imem_data, imem_valid, exc_out, exc_jmpAdd, load
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer feeding the 8-bit ALU.
// Define CTRL_RETIRE_CNT_EN to build the 16-bit retired-instruction counter.
module control_unit #(
    parameter logic [7:0] RST_PC = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    control_unit_if.master bus,
    output logic [7:0]     pc,
    output logic           retire,
    output logic           halted,
    output logic [15:0]    instret
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  rf_q [4];
    logic        rf_we;
    logic [7:0]  rf_wdata;
    logic        retire_q, retire_d;
    logic [3:0]  alu_opcode_q, alu_opcode_d;
    logic        alu_type_q, alu_type_d;
    logic [7:0]  alu_reg1_q, alu_reg1_d;
    logic [7:0]  alu_reg2_q, alu_reg2_d;
    logic [7:0]  alu_pc_q, alu_pc_d;
    logic [7:0]  alu_jmpAdd_q, alu_jmpAdd_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        rf_we        = 1'b0;
        rf_wdata     = bus.exc_out;
        retire_d     = 1'b0;
        alu_opcode_d = alu_opcode_q;
        alu_type_d   = alu_type_q;
        alu_reg1_d   = alu_reg1_q;
        alu_reg2_d   = alu_reg2_q;
        alu_pc_d     = alu_pc_q;
        alu_jmpAdd_d = alu_jmpAdd_q;

        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_opcode_d = ir_q[15:12];
                alu_type_d   = ir_q[11];
                alu_reg1_d   = rf_q[ir_q[10:9]];
                alu_reg2_d   = rf_q[ir_q[8:7]];
                alu_pc_d     = pc_q;
                alu_jmpAdd_d = ir_q[7:0];
                state_d      = S_WB;
            end
            S_WB: begin
                retire_d = 1'b1;
                state_d  = S_FETCH;
                if (!ir_q[11]) begin
                    rf_we = 1'b1;
                    pc_d  = bus.load ? bus.exc_jmpAdd : pc_q + 8'd1;
                end else begin
                    case (ir_q[15:12])
                        4'h0: pc_d = bus.exc_jmpAdd;
                        4'h1: begin
                            rf_we = 1'b1;
                            pc_d  = bus.exc_jmpAdd;
                        end
                        4'h2: begin
                            rf_we    = 1'b1;
                            rf_wdata = ir_q[7:0];
                            pc_d     = pc_q + 8'd1;
                        end
                        4'hF:    state_d = S_HALT;
                        default: pc_d = pc_q + 8'd1;
                    endcase
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RST_PC;
            ir_q         <= '0;
            retire_q     <= 1'b0;
            alu_opcode_q <= '0;
            alu_type_q   <= 1'b0;
            alu_reg1_q   <= '0;
            alu_reg2_q   <= '0;
            alu_pc_q     <= '0;
            alu_jmpAdd_q <= '0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            retire_q     <= retire_d;
            alu_opcode_q <= alu_opcode_d;
            alu_type_q   <= alu_type_d;
            alu_reg1_q   <= alu_reg1_d;
            alu_reg2_q   <= alu_reg2_d;
            alu_pc_q     <= alu_pc_d;
            alu_jmpAdd_q <= alu_jmpAdd_d;
            if (rf_we) rf_q[ir_q[10:9]] <= rf_wdata;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] instret_q;

    // Counts at the WB edge so the new value appears together with the retire pulse.
    always_ff @(posedge clk) begin
        if (rst)           instret_q <= '0;
        else if (retire_d) instret_q <= instret_q + 16'd1;
    end

    assign instret = instret_q;
`else
    assign instret = 16'h0000;
`endif

    assign bus.imem_addr  = pc_q;
    assign bus.imem_rd    = (state_q == S_FETCH);
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_type   = alu_type_q;
    assign bus.alu_reg1   = alu_reg1_q;
    assign bus.alu_reg2   = alu_reg2_q;
    assign bus.alu_pc     = alu_pc_q;
    assign bus.alu_jmpAdd = alu_jmpAdd_q;
    assign pc             = pc_q;
    assign retire         = retire_q;
    assign halted         = (state_q == S_HALT);
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: small program in a model memory plus a
// behavioural ALU, checked against hand-computed PC/register/ALU-bus values.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  pc;
    logic        retire;
    logic        halted;
    logic [15:0] instret;

    control_unit_if bus ();

    control_unit dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bus     (bus),
        .pc      (pc),
        .retire  (retire),
        .halted  (halted),
        .instret (instret)
    );

    always #5 clk = ~clk;

`ifdef CTRL_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Behavioural ALU; LDI/NOP deliberately raise load with a bogus target.
    logic [7:0] dec;
    always_comb begin
        bus.exc_out    = 8'h00;
        bus.exc_jmpAdd = 8'h00;
        bus.load       = 1'b0;
        dec            = bus.alu_reg1 - 8'd1;
        if (!bus.alu_type) begin
            case (bus.alu_opcode)
                4'h0:    bus.exc_out = bus.alu_reg1 + bus.alu_reg2;
                4'h1:    bus.exc_out = bus.alu_reg1 - bus.alu_reg2;
                default: bus.exc_out = bus.alu_reg1 ^ bus.alu_reg2;
            endcase
        end else if (bus.alu_opcode == 4'h0) begin
            bus.exc_out    = 8'hEE;
            bus.exc_jmpAdd = bus.alu_jmpAdd;
            bus.load       = 1'b1;
        end else if (bus.alu_opcode == 4'h1) begin
            bus.exc_out    = dec;
            bus.exc_jmpAdd = (dec == 8'h00) ? bus.alu_pc + 8'd2 : bus.alu_pc + 8'd1;
        end else if (bus.alu_opcode != 4'hF) begin
            bus.exc_out    = 8'hEE;
            bus.exc_jmpAdd = 8'hEE;
            bus.load       = 1'b1;
        end
    end

    // Synchronous instruction memory with an optional one-shot stall on one address.
    logic [15:0] mem [256];
    logic [7:0]  stall_addr = 8'h25;
    int          stall_len  = 5;
    logic        pend       = 1'b0;
    logic [7:0]  addr_l;
    int          cnt;

    initial begin
        bus.imem_data  = 16'h0000;
        bus.imem_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_valid = 1'b0;
            if (bus.imem_rd) begin
                pend   = 1'b1;
                addr_l = bus.imem_addr;
                cnt    = (addr_l == stall_addr) ? stall_len : 0;
                if (addr_l == stall_addr) stall_len = 0;
            end else if (pend) begin
                if (cnt == 0) begin
                    bus.imem_data  = mem[addr_l];
                    bus.imem_valid = 1'b1;
                    pend           = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, pc, 8'h00);
        check({tag, "_imem_addr"}, bus.imem_addr, 8'h00);
        check({tag, "_imem_rd"}, bus.imem_rd, 1'b0);
        check({tag, "_alu_opcode"}, bus.alu_opcode, 4'h0);
        check({tag, "_alu_type"}, bus.alu_type, 1'b0);
        check({tag, "_alu_reg1"}, bus.alu_reg1, 8'h00);
        check({tag, "_alu_reg2"}, bus.alu_reg2, 8'h00);
        check({tag, "_alu_pc"}, bus.alu_pc, 8'h00);
        check({tag, "_alu_jmpAdd"}, bus.alu_jmpAdd, 8'h00);
        check({tag, "_retire"}, retire, 1'b0);
        check({tag, "_halted"}, halted, 1'b0);
        check({tag, "_instret"}, instret, 16'h0000);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check_reset(tag);
        rst = 1'b0;
    endtask

    task automatic start();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Returns at the negedge of the cycle in which retire is high (bounded).
    task automatic wait_retire(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!retire && cycles < 40);
        check({tag, "_retire"}, retire, 1'b1);
    endtask

    int c;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h3800;
        mem[8'h00] = 16'h2805;  // LDI R0,05
        mem[8'h01] = 16'h2A03;  // LDI R1,03
        mem[8'h02] = 16'h0080;  // ADD R0,R1
        mem[8'h03] = 16'h1200;  // SUB R1,R0
        mem[8'h04] = 16'h3A00;  // NOP rd=R1 (probe)
        mem[8'h05] = 16'h2C01;  // LDI R2,01
        mem[8'h06] = 16'h0810;  // JMP 10
        mem[8'h10] = 16'h0840;  // JMP 40
        mem[8'h40] = 16'h3800;  // NOP rd=R0 (probe)
        mem[8'h41] = 16'h0820;  // JMP 20
        mem[8'h20] = 16'h1C00;  // DSKIP R2
        mem[8'h22] = 16'h2C03;  // LDI R2,03
        mem[8'h23] = 16'h1C00;  // DSKIP R2
        mem[8'h24] = 16'h3C00;  // NOP rd=R2 (probe)
        mem[8'h25] = 16'h2E7E;  // LDI R3,7E (stalled fetch)
        mem[8'h26] = 16'h3E00;  // NOP rd=R3 (probe)
        mem[8'h27] = 16'h28AA;  // LDI R0,AA (killed by reset)

        do_reset("rst0");
        start();

        wait_retire("ldi0", c);
        check("ldi0_cycles", c, 4);
        check("ldi0_pc", pc, 8'h01);
        check("ldi0_opcode", bus.alu_opcode, 4'h2);
        check("ldi0_type", bus.alu_type, 1'b1);
        check("ldi0_jmpAdd", bus.alu_jmpAdd, 8'h05);
        wait_retire("ldi1", c);
        check("ldi1_pc", pc, 8'h02);
        wait_retire("add", c);
        check("add_cycles", c, 4);
        check("add_pc", pc, 8'h03);
        check("add_reg1", bus.alu_reg1, 8'h05);
        check("add_reg2", bus.alu_reg2, 8'h03);
        check("add_type", bus.alu_type, 1'b0);
        @(negedge clk);
        check("retire_width", retire, 1'b0);
        check("instret_3", instret, CNT_EN ? 16'd3 : 16'd0);
        wait_retire("sub", c);
        check("sub_pc", pc, 8'h04);
        check("sub_reg1", bus.alu_reg1, 8'h03);
        check("sub_reg2", bus.alu_reg2, 8'h08);
        wait_retire("probe_r1", c);
        check("probe_r1_val", bus.alu_reg1, 8'hFB);
        check("nop_ignores_load", pc, 8'h05);
        wait_retire("ldi_r2", c);
        wait_retire("jmp10", c);
        check("jmp10_pc", pc, 8'h10);
        wait_retire("jmp40", c);
        check("jmp40_pc", pc, 8'h40);
        check("jmp40_imem_addr", bus.imem_addr, 8'h40);
        check("jmp40_imem_rd", bus.imem_rd, 1'b1);
        wait_retire("probe_r0", c);
        check("probe_r0_val", bus.alu_reg1, 8'h08);
        wait_retire("jmp20", c);
        check("jmp20_pc", pc, 8'h20);
        wait_retire("dskip1", c);
        check("dskip1_pc", pc, 8'h22);
        check("dskip1_reg1", bus.alu_reg1, 8'h01);
        check("dskip1_alu_pc", bus.alu_pc, 8'h20);
        wait_retire("ldi_r2b", c);
        check("r2_after_dskip1", bus.alu_reg1, 8'h00);
        check("ldi_r2b_pc", pc, 8'h23);
        wait_retire("dskip3", c);
        check("dskip3_pc", pc, 8'h24);
        wait_retire("probe_r2", c);
        check("probe_r2_val", bus.alu_reg1, 8'h02);
        check("probe_r2_pc", pc, 8'h25);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_retire", retire, 1'b0);
            check("stall_pc", pc, 8'h25);
            check("stall_imem_rd", bus.imem_rd, 1'b0);
        end
        wait_retire("stall_ldi", c);
        check("stall_tail_cycles", c, 4);
        check("stall_ldi_pc", pc, 8'h26);
        wait_retire("probe_r3", c);
        check("probe_r3_val", bus.alu_reg1, 8'h7E);

        @(negedge clk);  // DECODE of LDI R0,AA
        @(negedge clk);  // EXEC
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_exec");
        rst = 1'b0;

        mem[8'h01] = 16'h08FF;  // JMP FF
        mem[8'h05] = 16'hF800;  // HALT
        start();
        wait_retire("p2_ldi", c);
        check("r0_not_written", bus.alu_reg1, 8'h00);
        check("p2_ldi_pc", pc, 8'h01);
        mem[8'h00] = 16'h0805;  // JMP 05 on the next visit
        wait_retire("p2_jmpff", c);
        check("p2_jmpff_pc", pc, 8'hFF);
        wait_retire("nop_wrap", c);
        check("nop_wrap_pc", pc, 8'h00);
        wait_retire("p2_jmp05", c);
        check("p2_jmp05_pc", pc, 8'h05);
        wait_retire("halt", c);
        check("halt_pc", pc, 8'h05);
        check("halt_halted", halted, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run = i[0];
            @(negedge clk);
            check("halt_imem_rd", bus.imem_rd, 1'b0);
            check("halt_retire", retire, 1'b0);
            check("halt_hold", halted, 1'b1);
            check("halt_pc_hold", pc, 8'h05);
        end
        check("instret_5", instret, CNT_EN ? 16'd5 : 16'd0);
        do_reset("rst_halt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
